// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS execute-control slice.
// Both the sequencer and the ALU use the ALU opcode enum from this package.
// The package also holds the opcode, funct and REGIMM rt encodings, the
// sequencer state enum, the decoder output struct and the branch condition
// helper.
package mips_cpu_pkg;

  // ALU opcode shared by the sequencer and the ALU datapath.
  typedef enum logic [3:0] {
    ALU_ADDU = 4'h0,
    ALU_SUBU = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SRL  = 4'h5,
    ALU_SRA  = 4'h6,
    ALU_SLL  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9
  } alu_control_t;

  // Primary opcodes (instr[31:26]).
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;

  // R-type funct codes (instr[5:0]).
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // REGIMM rt selectors (instr[20:16]).
  localparam logic [4:0] RT_BLTZ = 5'h00;
  localparam logic [4:0] RT_BGEZ = 5'h01;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DECODE    = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_ALU     = 2'd0,
    CLS_BRANCH  = 2'd1,
    CLS_ILLEGAL = 2'd2
  } instr_class_t;

  typedef enum logic [2:0] {
    BR_EQ  = 3'd0,
    BR_NE  = 3'd1,
    BR_LEZ = 3'd2,
    BR_GTZ = 3'd3,
    BR_LTZ = 3'd4,
    BR_GEZ = 3'd5
  } branch_cond_t;

  typedef struct packed {
    alu_control_t alu_ctrl;
    logic [4:0]   shift_amt;
    logic         src_imm;
    logic         sign_ext;
    logic         dst_rd;
    instr_class_t cls;
    branch_cond_t cond;
  } decode_t;

  // Debug view of the sequencer: state, latched class and sampled flags
  // (flags ordered {zero, equal, negative}).
  typedef struct packed {
    state_t       state;
    instr_class_t cls;
    logic [2:0]   flags;
  } dbg_t;

  function automatic logic branch_cond_met(input branch_cond_t cond,
                                           input logic zero,
                                           input logic equal,
                                           input logic negative);
    logic taken;
    taken = 1'b0;
    case (cond)
      BR_EQ:   taken = equal;
      BR_NE:   taken = !equal;
      BR_LEZ:  taken = zero | negative;
      BR_GTZ:  taken = !zero & !negative;
      BR_LTZ:  taken = negative;
      BR_GEZ:  taken = !negative;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/mips_cpu_exec_control_if.sv
// Bundle of the signals between the execute-control sequencer and its
// surroundings (fetch stage, register file, ALU).
//
// Handshake: an instruction transfers on a rising clk edge where
// instr_valid && instr_ready are both 1. Once instr_valid is raised, instr
// must stay stable until that edge. instr_ready depends only on the
// sequencer state and reset, never on instr_valid.
//
// Modports:
//   slave  - the sequencer: takes instructions, rs_shamt and ALU flags;
//            drives ALU controls, write-back/branch pulses and done.
//   master - the environment driving the sequencer (fetch + datapath).
interface mips_cpu_exec_control_if;
  import mips_cpu_pkg::*;

  logic         instr_valid;
  logic         instr_ready;
  logic [31:0]  instr;
  logic [4:0]   rs_shamt;
  alu_control_t alu_control;
  logic [4:0]   alu_shift_amt;
  logic         alu_src_imm;
  logic         imm_sign_ext;
  logic         zero;
  logic         equal;
  logic         negative;
  logic         reg_write;
  logic         reg_dst_rd;
  logic         branch_taken;
  logic         illegal;
  logic         done;

  modport slave (
    input  instr_valid, instr, rs_shamt, zero, equal, negative,
    output instr_ready, alu_control, alu_shift_amt, alu_src_imm,
           imm_sign_ext, reg_write, reg_dst_rd, branch_taken, illegal, done
  );

  modport master (
    output instr_valid, instr, rs_shamt, zero, equal, negative,
    input  instr_ready, alu_control, alu_shift_amt, alu_src_imm,
           imm_sign_ext, reg_write, reg_dst_rd, branch_taken, illegal, done
  );

endinterface

// File: rtl/mips_cpu_alu_op_decode.sv
// Purely combinational instruction decoder.
// Ports:
//   instr    in  32  latched instruction word
//   rs_shamt in  5   rs[4:0] from the register file, used by variable shifts
//   dec      out     decode_t: ALU opcode, shift amount, operand selects,
//                    instruction class and branch condition
// Anything not recognised is classed illegal with all controls at their
// defaults (ADDU, shift 0, selects 0).
module mips_cpu_alu_op_decode
  import mips_cpu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [4:0]  rs_shamt,
  output decode_t     dec
);

  logic [5:0] w_opcode;
  logic [5:0] w_funct;
  logic [4:0] w_rt;
  logic [4:0] w_shamt;
  logic       w_unused;

  assign w_opcode = instr[31:26];
  assign w_funct  = instr[5:0];
  assign w_rt     = instr[20:16];
  assign w_shamt  = instr[10:6];
  // rs and rd fields are routed to the register file, not needed here.
  assign w_unused = ^{instr[25:21], instr[15:11]};

  always_comb begin
    dec          = '0;
    dec.alu_ctrl = ALU_ADDU;
    dec.cls      = CLS_ILLEGAL;
    dec.cond     = BR_EQ;

    case (w_opcode)
      OP_RTYPE: begin
        dec.cls    = CLS_ALU;
        dec.dst_rd = 1'b1;
        case (w_funct)
          FN_ADDU: dec.alu_ctrl = ALU_ADDU;
          FN_SUBU: dec.alu_ctrl = ALU_SUBU;
          FN_AND:  dec.alu_ctrl = ALU_AND;
          FN_OR:   dec.alu_ctrl = ALU_OR;
          FN_XOR:  dec.alu_ctrl = ALU_XOR;
          FN_SLT:  dec.alu_ctrl = ALU_SLT;
          FN_SLTU: dec.alu_ctrl = ALU_SLTU;
          FN_SLL:  begin dec.alu_ctrl = ALU_SLL; dec.shift_amt = w_shamt;  end
          FN_SRL:  begin dec.alu_ctrl = ALU_SRL; dec.shift_amt = w_shamt;  end
          FN_SRA:  begin dec.alu_ctrl = ALU_SRA; dec.shift_amt = w_shamt;  end
          FN_SLLV: begin dec.alu_ctrl = ALU_SLL; dec.shift_amt = rs_shamt; end
          FN_SRLV: begin dec.alu_ctrl = ALU_SRL; dec.shift_amt = rs_shamt; end
          FN_SRAV: begin dec.alu_ctrl = ALU_SRA; dec.shift_amt = rs_shamt; end
          default: begin
            dec.cls    = CLS_ILLEGAL;
            dec.dst_rd = 1'b0;
          end
        endcase
      end

      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        dec.cls      = CLS_ALU;
        dec.src_imm  = 1'b1;
        // Arithmetic/compare immediates are signed; logical ones are not.
        dec.sign_ext = (w_opcode == OP_ADDIU) || (w_opcode == OP_SLTI) ||
                       (w_opcode == OP_SLTIU);
        case (w_opcode)
          OP_SLTI:  dec.alu_ctrl = ALU_SLT;
          OP_SLTIU: dec.alu_ctrl = ALU_SLTU;
          OP_ANDI:  dec.alu_ctrl = ALU_AND;
          OP_ORI:   dec.alu_ctrl = ALU_OR;
          OP_XORI:  dec.alu_ctrl = ALU_XOR;
          default:  dec.alu_ctrl = ALU_ADDU;
        endcase
      end

      // Branches compare through the ALU subtractor; flags pick the outcome.
      OP_BEQ:  begin dec.cls = CLS_BRANCH; dec.alu_ctrl = ALU_SUBU; dec.cond = BR_EQ;  end
      OP_BNE:  begin dec.cls = CLS_BRANCH; dec.alu_ctrl = ALU_SUBU; dec.cond = BR_NE;  end
      OP_BLEZ: begin dec.cls = CLS_BRANCH; dec.alu_ctrl = ALU_SUBU; dec.cond = BR_LEZ; end
      OP_BGTZ: begin dec.cls = CLS_BRANCH; dec.alu_ctrl = ALU_SUBU; dec.cond = BR_GTZ; end

      OP_REGIMM: begin
        if (w_rt == RT_BLTZ) begin
          dec.cls      = CLS_BRANCH;
          dec.alu_ctrl = ALU_SUBU;
          dec.cond     = BR_LTZ;
        end else if (w_rt == RT_BGEZ) begin
          dec.cls      = CLS_BRANCH;
          dec.alu_ctrl = ALU_SUBU;
          dec.cond     = BR_GEZ;
        end
      end

      default: ;
    endcase
  end

endmodule

// File: rtl/mips_cpu_exec_control.sv
// Multi-cycle execute-control sequencer.
// Takes one instruction per handshake, decodes it, holds the ALU controls
// for one execute cycle, samples the ALU flags, then pulses reg_write,
// branch_taken or illegal together with done. Each instruction occupies
// exactly four cycles: IDLE -> DECODE -> EXECUTE -> WRITEBACK.
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of mips_cpu_exec_control_if (fetch handshake,
//            rs_shamt, ALU controls and flags, write-back/branch pulses)
//   dbg      out  state, latched class and sampled flags
module mips_cpu_exec_control
  import mips_cpu_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset_n,
  mips_cpu_exec_control_if.slave         bus,
  output dbg_t                           dbg
);

  state_t       r_state;
  logic [31:0]  r_instr;
  alu_control_t r_alu_control;
  logic [4:0]   r_shift_amt;
  logic         r_src_imm;
  logic         r_sign_ext;
  logic         r_dst_rd;
  instr_class_t r_cls;
  branch_cond_t r_cond;
  logic [2:0]   r_flags;
  logic         r_reg_write;
  logic         r_branch_taken;
  logic         r_illegal;
  logic         r_done;

  decode_t      w_dec;

  // Decodes the latched word; rs_shamt is consumed while in DECODE.
  mips_cpu_alu_op_decode u_decode (
    .instr    (r_instr),
    .rs_shamt (bus.rs_shamt),
    .dec      (w_dec)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_instr        <= '0;
      r_alu_control  <= ALU_ADDU;
      r_shift_amt    <= '0;
      r_src_imm      <= 1'b0;
      r_sign_ext     <= 1'b0;
      r_dst_rd       <= 1'b0;
      r_cls          <= CLS_ALU;
      r_cond         <= BR_EQ;
      r_flags        <= '0;
      r_reg_write    <= 1'b0;
      r_branch_taken <= 1'b0;
      r_illegal      <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      // Pulses last one cycle unless re-armed below.
      r_reg_write    <= 1'b0;
      r_branch_taken <= 1'b0;
      r_illegal      <= 1'b0;
      r_done         <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (bus.instr_valid) begin
            r_instr <= bus.instr;
            r_state <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          r_alu_control <= w_dec.alu_ctrl;
          r_shift_amt   <= w_dec.shift_amt;
          r_src_imm     <= w_dec.src_imm;
          r_sign_ext    <= w_dec.sign_ext;
          r_dst_rd      <= w_dec.dst_rd;
          r_cls         <= w_dec.cls;
          r_cond        <= w_dec.cond;
          r_state       <= ST_EXECUTE;
        end

        ST_EXECUTE: begin
          // Flags are sampled on this edge only; the write-back pulses are
          // formed from the same sampled values so they appear registered.
          r_flags        <= {bus.zero, bus.equal, bus.negative};
          r_done         <= 1'b1;
          r_reg_write    <= (r_cls == CLS_ALU);
          r_illegal      <= (r_cls == CLS_ILLEGAL);
          r_branch_taken <= (r_cls == CLS_BRANCH) &&
                            branch_cond_met(r_cond, bus.zero, bus.equal,
                                            bus.negative);
          r_state        <= ST_WRITEBACK;
        end

        ST_WRITEBACK: begin
          r_alu_control <= ALU_ADDU;
          r_shift_amt   <= '0;
          r_src_imm     <= 1'b0;
          r_sign_ext    <= 1'b0;
          r_dst_rd      <= 1'b0;
          r_instr       <= '0;
          r_state       <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Qualified with reset_n so ready is low while reset is held and high in
  // the first cycle after release.
  assign bus.instr_ready   = (r_state == ST_IDLE) && reset_n;
  assign bus.alu_control   = r_alu_control;
  assign bus.alu_shift_amt = r_shift_amt;
  assign bus.alu_src_imm   = r_src_imm;
  assign bus.imm_sign_ext  = r_sign_ext;
  assign bus.reg_dst_rd    = r_dst_rd;
  assign bus.reg_write     = r_reg_write;
  assign bus.branch_taken  = r_branch_taken;
  assign bus.illegal       = r_illegal;
  assign bus.done          = r_done;

  assign dbg.state = r_state;
  assign dbg.cls   = r_cls;
  assign dbg.flags = r_flags;

endmodule

// File: doc/mips_cpu_exec_control.md
Name: mips_cpu_exec_control

Overview:
Multi-cycle control sequencer that drives the shared ALU's control interface and consumes its flag outputs.
- Accepts one 32-bit MIPS instruction per handshake and decodes it to an ALU opcode, shift amount and operand-source selects.
- Holds those controls stable for one execute cycle, samples the ALU zero/equal/negative flags, then issues register write-back or a branch-taken decision.
- Sits between the fetch stage and the register file / ALU datapath.

Parameters:
- None. All opcode and funct encodings come from the shared package.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instr holds a valid instruction
- instr_ready  out  1  sequencer can accept an instruction
- instr  in  32  instruction word
- rs_shamt  in  5  rs[4:0] from register file; used by variable shifts
- alu_control  out  4  ALU opcode (shared enum)
- alu_shift_amt  out  5  ALU shift amount
- alu_src_imm  out  1  1: alu_b = extended immediate; 0: alu_b = rt data
- imm_sign_ext  out  1  1: sign-extend imm16; 0: zero-extend
- zero  in  1  ALU flag, alu_a == 0
- equal  in  1  ALU flag, alu_a == alu_b
- negative  in  1  ALU flag, alu_a < 0 signed
- reg_write  out  1  one-cycle write-enable pulse
- reg_dst_rd  out  1  1: destination is rd; 0: destination is rt
- branch_taken  out  1  one-cycle pulse; PC takes branch target
- illegal  out  1  one-cycle pulse; unsupported encoding
- done  out  1  one-cycle pulse; instruction retired

Behaviour:
- States: IDLE -> DECODE -> EXECUTE -> WRITEBACK -> IDLE. Fixed 4-cycle occupancy per instruction; no overlap.
- IDLE
  - instr_ready = 1.
  - When instr_valid && instr_ready, latch instr; go to DECODE.
  - When instr_valid = 0, stay in IDLE.
- DECODE
  - Register alu_control, alu_shift_amt, alu_src_imm, imm_sign_ext, reg_dst_rd and the internal class (alu/branch/illegal).
  - Registered values are valid throughout EXECUTE and WRITEBACK.
- EXECUTE
  - Controls held stable.
  - On the closing edge, register zero/equal/negative. Flags are sampled only here.
- WRITEBACK
  - ALU class: reg_write = 1.
  - Branch class: branch_taken = condition on the sampled flags.
  - Illegal class: illegal = 1.
  - done = 1 in every case. Return to IDLE.
- R-type (opcode 0x00), funct decode:
  - 0x21 ADDU, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x26 XOR, 0x2A STL, 0x2B STLU.
  - 0x00 SLL, 0x02 SRL, 0x03 SRA: shift amount = instr[10:6].
  - 0x04 SLLV, 0x06 SRLV, 0x07 SRAV: shift amount = rs_shamt, sampled in DECODE.
  - reg_dst_rd = 1, alu_src_imm = 0.
- I-type ALU: reg_dst_rd = 0, alu_src_imm = 1.
  - 0x09 ADDIU, 0x0A SLTI, 0x0B SLTIU: sign-extend.
  - 0x0C ANDI, 0x0D ORI, 0x0E XORI: zero-extend.
- Branches: alu_control = SUBU, alu_src_imm = 0, reg_write never asserted.
  - 0x04 BEQ: taken = equal.
  - 0x05 BNE: taken = !equal.
  - 0x06 BLEZ: taken = zero | negative.
  - 0x07 BGTZ: taken = !zero & !negative.
  - 0x01 with rt = 0 BLTZ: taken = negative.
  - 0x01 with rt = 1 BGEZ: taken = !negative.
- Illegal: any other opcode, funct, or REGIMM rt. No reg_write, no branch_taken.
- Output defaults
  - All pulse outputs are 0 outside WRITEBACK.
  - Outside EXECUTE and WRITEBACK: alu_control = ADDU (4'h0), alu_shift_amt = 0, all select outputs = 0.
- Instruction 0x00000000 (NOP = SLL $0,$0,0) retires as a normal ALU op with reg_write = 1 and destination $0. The register file discards the write.
- Reset
  - reset_n low at any time, including mid-instruction: immediately go to IDLE, clear the latched instruction, drive all outputs to defaults.
  - instr_ready is 0 while reset_n is low and 1 in the first cycle after release.
  - No pulse is emitted for the aborted instruction.
- instr_valid held high across WRITEBACK: the next instruction is accepted only in IDLE, so back-to-back issue rate is 1 instruction per 4 cycles.

Decomposition:
- Package mips_cpu_pkg holds:
  - alu_control_t enum, moved out of the ALU so both ends share it;
  - opcode, funct and REGIMM rt localparams;
  - the state enum.
- Sub-module mips_cpu_alu_op_decode: purely combinational. Maps instr to alu_control, shift source, operand selects and class. Instantiated once in DECODE.

Test Plan:
- ADDU $3,$1,$2 (0x00221821) accepted at cycle 0 -> alu_control = 0x0 in cycles 2-3; reg_write, reg_dst_rd and done high in cycle 3 only; instr_ready high again in cycle 4.
- SRAV (0x00A21807) with rs_shamt = 5'd7 -> alu_control = 0x6 and alu_shift_amt = 7 during EXECUTE; SRA 0x00021903 -> alu_shift_amt = 4.
- BEQ 0x10220004: equal = 1 in EXECUTE -> branch_taken pulse in WRITEBACK; equal = 0 -> no pulse. BGTZ with zero = 0, negative = 0 -> taken; with negative = 1 -> not taken.
- ORI 0x3441FFFF -> alu_control = 0x3, alu_src_imm = 1, imm_sign_ext = 0, reg_dst_rd = 0; ADDIU 0x2441FFFF -> imm_sign_ext = 1.
- Opcode 0x3F, and REGIMM with rt = 5 -> illegal and done pulse in WRITEBACK; no reg_write, no branch_taken.
- reset_n dropped during EXECUTE of an ADDU -> outputs immediately at defaults; no reg_write or done; after release, instr_ready = 1 and the next instruction executes normally.
